// File: rtl/riscv_mem_pkg.sv
// Shared Funct3 encodings, responder FSM states and alignment helper.
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

  // Halfwords need addr[0]=0, words need addr[1:0]=0; bytes are always aligned.
  function automatic logic is_misaligned(input logic [2:0] funct3, input logic [1:0] addr_lo);
    logic half;
    logic word;
    half = (funct3 == F3_H) || (funct3 == F3_HU);
    word = (funct3 == F3_W);
    return (half && addr_lo[0]) || (word && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage load/store bus between the pipeline (master) and the responder (slave).
interface dmem_responder_if;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_funct3;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic        stall;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_funct3,
    input  req_ready, resp_valid, resp_rdata, resp_err, stall
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_funct3,
    output req_ready, resp_valid, resp_rdata, resp_err, stall
  );

endinterface

// File: rtl/dmem_array.sv
// Word-organised synchronous RAM with byte write enables and a registered read port.
module dmem_array #(
  parameter int unsigned ADDR_W = 9,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              i_en,
  input  logic [3:0]        i_be,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Byte-lane write and read-before-write data capture on enabled cycles.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed latency, lane select and error checks.
module dmem_responder
  import riscv_mem_pkg::*;
#(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned ADDR_W  = 9,
  parameter int unsigned LATENCY = 2
) (
  input  logic          clk,
  input  logic          reset,
  dmem_responder_if.slave bus
);

  localparam int unsigned    CNT_W    = $clog2(LATENCY + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

  dmem_state_t       r_state, w_state_next;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_we, r_err;
  logic [ADDR_W+1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [2:0]        r_funct3;

  logic              w_accept, w_req_err, w_illegal, w_enter_resp;
  logic              w_op_we, w_op_err;
  logic [ADDR_W+1:0] w_op_addr;
  logic [DATA_W-1:0] w_op_wdata, w_lane_wdata, w_rdata;
  logic [2:0]        w_op_funct3;
  logic [3:0]        w_be;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;

  assign w_accept = (r_state == IDLE) && bus.req_valid;

  // Classify the incoming request: illegal Funct3, misalignment or out-of-range address.
  always_comb begin
    if (bus.req_we) w_illegal = !(bus.req_funct3 inside {F3_B, F3_H, F3_W});
    else            w_illegal = !(bus.req_funct3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU});
    w_req_err = w_illegal || is_misaligned(bus.req_funct3, bus.req_addr[1:0]) ||
                (bus.req_addr[31:ADDR_W+2] != '0);
  end

  // Capture the accepted request so it completes even if req_valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_we     <= 1'b0;
      r_err    <= 1'b0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_funct3 <= '0;
    end else if (w_accept) begin
      r_we     <= bus.req_we;
      r_err    <= w_req_err;
      r_addr   <= bus.req_addr[ADDR_W+1:0];
      r_wdata  <= bus.req_wdata;
      r_funct3 <= bus.req_funct3;
    end
  end

  // Wait counter: loaded to 1 on accept, WAIT ends when it reaches LATENCY-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 r_cnt <= '0;
    else if (r_state == WAIT)  r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + 1'b1;
    else if (w_accept)         r_cnt <= CNT_W'(1);
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_next;
  end

  // FSM next-state logic.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE: if (bus.req_valid) w_state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT: if (r_cnt == CNT_LAST) w_state_next = RESP;
      RESP: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // FSM outputs: handshake, stall and the extended load data.
  always_comb begin
    bus.req_ready  = (r_state == IDLE);
    bus.stall      = ((r_state == IDLE) && bus.req_valid) || (r_state == WAIT);
    bus.resp_valid = (r_state == RESP);
    bus.resp_err   = (r_state == RESP) && r_err;
    bus.resp_rdata = '0;
    if ((r_state == RESP) && !r_err && !r_we) begin
      case (r_funct3)
        F3_B:    bus.resp_rdata = {{24{w_byte[7]}}, w_byte};
        F3_H:    bus.resp_rdata = {{16{w_half[15]}}, w_half};
        F3_W:    bus.resp_rdata = w_rdata;
        F3_BU:   bus.resp_rdata = {24'h0, w_byte};
        F3_HU:   bus.resp_rdata = {16'h0, w_half};
        default: bus.resp_rdata = '0;
      endcase
    end
  end

  // With LATENCY=1 the array is accessed straight from IDLE, before the capture registers load.
  always_comb begin
    if (r_state == IDLE) begin
      w_op_we     = bus.req_we;
      w_op_err    = w_req_err;
      w_op_addr   = bus.req_addr[ADDR_W+1:0];
      w_op_wdata  = bus.req_wdata;
      w_op_funct3 = bus.req_funct3;
    end else begin
      w_op_we     = r_we;
      w_op_err    = r_err;
      w_op_addr   = r_addr;
      w_op_wdata  = r_wdata;
      w_op_funct3 = r_funct3;
    end
  end

  // Read and store commit happen on the edge entering RESP; reset blocks a pending commit.
  assign w_enter_resp = (w_state_next == RESP) && (r_state != RESP) && !reset;

  // Store lane replication and byte enables.
  always_comb begin
    w_be         = 4'b0000;
    w_lane_wdata = w_op_wdata;
    case (w_op_funct3[1:0])
      2'b00: begin
        w_be         = 4'b0001 << w_op_addr[1:0];
        w_lane_wdata = {4{w_op_wdata[7:0]}};
      end
      2'b01: begin
        w_be         = w_op_addr[1] ? 4'b1100 : 4'b0011;
        w_lane_wdata = {2{w_op_wdata[15:0]}};
      end
      2'b10:   w_be = 4'b1111;
      default: w_be = 4'b0000;
    endcase
    if (!(w_enter_resp && w_op_we && !w_op_err)) w_be = 4'b0000;
  end

  // Load lane selection from the registered read word.
  always_comb begin
    case (r_addr[1:0])
      2'd0:    w_byte = w_rdata[7:0];
      2'd1:    w_byte = w_rdata[15:8];
      2'd2:    w_byte = w_rdata[23:16];
      default: w_byte = w_rdata[31:24];
    endcase
    w_half = r_addr[1] ? w_rdata[31:16] : w_rdata[15:0];
  end

  dmem_array #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_array (
    .clk     (clk),
    .i_en    (w_enter_resp),
    .i_be    (w_be),
    .i_addr  (w_op_addr[ADDR_W+1:2]),
    .i_wdata (w_lane_wdata),
    .o_rdata (w_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder at LATENCY=2.
module tb_dmem_responder;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;
  exp_t sb_q[$];

  dmem_responder_if bus ();

  dmem_responder #(
    .DATA_W  (32),
    .ADDR_W  (9),
    .LATENCY (2)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every response pulse pops one expectation.
  always @(negedge clk) begin
    if (!reset && bus.resp_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_resp: got resp_valid=1 rdata=0x%08h expected no response",
                 bus.resp_rdata);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check({e.name, "_rdata"}, bus.resp_rdata, e.rdata);
        check({e.name, "_err"}, {31'b0, bus.resp_err}, {31'b0, e.err});
      end
    end
  end

  // Issue one request (called just after a rising edge, DUT idle) and check its timing.
  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [2:0] f3,
                        input logic [31:0] exp_rdata, input logic exp_err);
    exp_t e;
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_addr   = addr;
    bus.req_wdata  = wdata;
    bus.req_funct3 = f3;
    e.rdata = exp_rdata;
    e.err   = exp_err;
    e.name  = name;
    sb_q.push_back(e);
    @(negedge clk);
    check({name, "_c0_stall"}, {31'b0, bus.stall}, 32'd1);
    @(posedge clk); #1;
    @(negedge clk);
    check({name, "_c1_stall"}, {31'b0, bus.stall}, 32'd1);
    check({name, "_c1_valid"}, {31'b0, bus.resp_valid}, 32'd0);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check({name, "_c2_valid"}, {31'b0, bus.resp_valid}, 32'd1);
    check({name, "_c2_stall"}, {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    reset          = 1'b1;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.req_funct3 = '0;
    repeat (2) @(negedge clk);
    check("rst_ready", {31'b0, bus.req_ready}, 32'd1);
    check("rst_stall", {31'b0, bus.stall}, 32'd0);
    check("rst_valid", {31'b0, bus.resp_valid}, 32'd0);
    check("rst_err",   {31'b0, bus.resp_err}, 32'd0);
    check("rst_rdata", bus.resp_rdata, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;

    do_req("sw10",   1'b1, 32'h10,  32'hDEADBEEF, 3'b010, 32'h0,        1'b0);
    do_req("lw10a",  1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADBEEF, 1'b0);
    do_req("lb13",   1'b0, 32'h13,  32'h0,        3'b000, 32'hFFFFFFDE, 1'b0);
    do_req("lbu13",  1'b0, 32'h13,  32'h0,        3'b100, 32'h000000DE, 1'b0);
    do_req("lh12",   1'b0, 32'h12,  32'h0,        3'b001, 32'hFFFFDEAD, 1'b0);
    do_req("lhu10",  1'b0, 32'h10,  32'h0,        3'b101, 32'h0000BEEF, 1'b0);
    do_req("sb11",   1'b1, 32'h11,  32'h000000AA, 3'b000, 32'h0,        1'b0);
    do_req("lw10b",  1'b0, 32'h10,  32'h0,        3'b010, 32'hDEADAAEF, 1'b0);
    do_req("sh12",   1'b1, 32'h12,  32'h00001234, 3'b001, 32'h0,        1'b0);
    do_req("lw10c",  1'b0, 32'h10,  32'h0,        3'b010, 32'h1234AAEF, 1'b0);
    do_req("lw12m",  1'b0, 32'h12,  32'h0,        3'b010, 32'h0,        1'b1);
    do_req("sh11m",  1'b1, 32'h11,  32'h0000FFFF, 3'b001, 32'h0,        1'b1);
    do_req("lw10d",  1'b0, 32'h10,  32'h0,        3'b010, 32'h1234AAEF, 1'b0);
    do_req("lw800",  1'b0, 32'h800, 32'h0,        3'b010, 32'h0,        1'b1);
    do_req("ld011",  1'b0, 32'h10,  32'h0,        3'b011, 32'h0,        1'b1);
    do_req("st100",  1'b1, 32'h10,  32'h0,        3'b100, 32'h0,        1'b1);
    do_req("lw10e",  1'b0, 32'h10,  32'h0,        3'b010, 32'h1234AAEF, 1'b0);
    do_req("sw20z",  1'b1, 32'h20,  32'h0,        3'b010, 32'h0,        1'b0);

    // Store aborted by reset while in WAIT: no response and no commit.
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_addr   = 32'h20;
    bus.req_wdata  = 32'h12345678;
    bus.req_funct3 = 3'b010;
    @(posedge clk); #1;
    reset         = 1'b1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'b0, bus.req_ready}, 32'd1);
    check("abort_stall", {31'b0, bus.stall}, 32'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("abort_novalid", {31'b0, bus.resp_valid}, 32'd0);
    end
    @(posedge clk); #1;
    do_req("lw20",   1'b0, 32'h20,  32'h0,        3'b010, 32'h00000000, 1'b0);

    repeat (3) @(posedge clk);
    check("sb_drained", sb_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder: the memory end of the processor's MEM-stage load/store interface (MemRead/MemWrite, address, store data, Funct3).
- Accepts one request at a time and returns data after a fixed, parameterised latency.
- Stalls the pipeline while a request is in flight.
- Performs byte/halfword/word lane selection, load sign/zero extension and misalignment/range error checks.

Parameters:
- DATA_W, 32: data width; only 32 is supported.
- ADDR_W, 9: word-address bits; the array holds 2^ADDR_W words (2 KiB at the default).
- LATENCY, 2: cycles from request acceptance to response; must be at least 1.

Ports:
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  request present; the requester holds all req_* signals stable while stall=1.
- req_ready  output  1  high only in IDLE.
- req_we  input  1  1 = store, 0 = load.
- req_addr  input  32  byte address.
- req_wdata  input  32  store data, right-aligned.
- req_funct3  input  3  RV32I load/store Funct3.
- resp_valid  output  1  single-cycle response pulse.
- resp_rdata  output  32  extended load data; 0 for stores and errors.
- resp_err  output  1  misaligned, illegal Funct3 or out-of-range access; valid with resp_valid.
- stall  output  1  pipeline hold request.

Behaviour:
- Reset values: state=IDLE, resp_valid=0, resp_rdata=0, resp_err=0, wait counter=0. req_ready=1 and stall=req_valid follow combinationally from IDLE.
- Array contents are not affected by reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - req_valid=1 accepts the request; this is cycle 0. Capture we, addr, wdata, funct3 and the error flag.
  - Go to WAIT, or straight to RESP when LATENCY=1.
- WAIT lasts exactly LATENCY-1 cycles, counted by a counter of width $clog2(LATENCY+1).
- RESP (cycle LATENCY):
  - resp_valid=1 for exactly one cycle; there is no back-pressure.
  - Next state is IDLE.
  - Throughput: one request per LATENCY+1 cycles.
- stall = (IDLE and req_valid) or WAIT. stall is low in RESP, so the pipeline advances and captures resp_rdata in that cycle.
- Read data and store commit both happen on the edge entering RESP.
- Error conditions (any one sets the flag):
  - Halfword access with addr[0]=1.
  - Word access with addr[1:0]≠0.
  - Load Funct3 not in {000, 001, 010, 100, 101}.
  - Store Funct3 not in {000, 001, 010}.
  - addr[31:ADDR_W+2] ≠ 0.
- On error: no write, resp_rdata=0, resp_err=1.
- Loads, little-endian, lane chosen by addr[1:0]:
  - LB (000) and LH (001) sign-extend.
  - LBU (100) and LHU (101) zero-extend.
  - LW (010) returns the full word.
- Stores:
  - SB writes wdata[7:0] to lane addr[1:0].
  - SH writes wdata[15:0] to lanes {addr[1],0} and {addr[1],1}.
  - SW writes all 4 lanes.
  - Other lanes are unchanged.
- Reset mid-operation (WAIT or RESP): return to IDLE immediately. A store not yet committed is discarded, and no resp_valid pulse is produced.
- req_valid deasserting during WAIT is ignored; the captured request completes.

Decomposition:
- Package riscv_mem_pkg:
  - Funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU.
  - State enum typedef dmem_state_t {IDLE, WAIT, RESP}.
  - Function is_misaligned(funct3, addr[1:0]).
- One sub-module, dmem_array: 2^ADDR_W×32 synchronous RAM with 4-bit byte-write-enable and a registered read port.
- Lane select, extension and error logic stay in dmem_responder.

Test Plan (LATENCY=2):
- Reset held, req_valid=0 -> req_ready=1, stall=0, resp_valid=0, resp_err=0, resp_rdata=0.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 -> each response in cycle 2 after acceptance, stall=1 in cycles 0–1; the LW returns rdata=0xDEADBEEF, err=0.
- Loads after the 0xDEADBEEF store:
  - LB 0x13 -> 0xFFFFFFDE.
  - LBU 0x13 -> 0x000000DE.
  - LH 0x12 -> 0xFFFFDEAD.
  - LHU 0x10 -> 0x0000BEEF.
- SB 0x11 data 0x000000AA, then LW 0x10 -> 0xDEADAAEF. SH 0x12 data 0x00001234, then LW 0x10 -> 0x1234AAEF.
- Error cases:
  - LW 0x12 -> resp_err=1, rdata=0.
  - SH 0x11 data 0xFFFF -> err=1, and a following LW 0x10 is unchanged.
  - LW 0x800 -> err=1.
  - Load Funct3 011 -> err=1.
- SW 0x20 0x0, then SW 0x20 0x12345678 with reset pulsed in WAIT -> no resp_valid, state IDLE; a following LW 0x20 returns 0x00000000.
